multicycle_control: RTL and testbench

Main control FSM for the multicycle RISC-V datapath. It sequences fetch, decode, execute, memory and write-back for R-type, I-type ALU, LW, SW and BEQ instructions. It drives `alu_op` into the existing ALU control decoder and the mux and enable strobes of the shared datapath. Memory accesses use a ready handshake so the FSM stalls on slow memory.

---
 rtl/multicycle_control.sv | 164 ++++++++++++++++
 tb/tb_multicycle_control.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RISC-V datapath (fetch/decode/execute/memory/write-back).
// Define MC_IMM_ALU_EN to add the EXEC_I state for I-type ALU instructions (opcode 0010011).
module multicycle_control #(
   parameter int OPCODE_W = 7
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   output logic                pc_write,
   output logic                pc_write_cond,
   output logic                pc_source,
   output logic                i_or_d,
   output logic                mem_read,
   output logic                mem_write,
   output logic                ir_write,
   output logic                reg_write,
   output logic                mem_to_reg,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [1:0]          alu_op,
   output logic [3:0]          state,
   output logic                retire,
   output logic                illegal_op
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC_R = 4'd6,
      ALUWB  = 4'd7,
      BRANCH = 4'd8,
      EXEC_I = 4'd9
   } state_t;

   localparam logic [OPCODE_W-1:0] OP_LOAD   = OPCODE_W'(7'b0000011);
   localparam logic [OPCODE_W-1:0] OP_STORE  = OPCODE_W'(7'b0100011);
   localparam logic [OPCODE_W-1:0] OP_RTYPE  = OPCODE_W'(7'b0110011);
   localparam logic [OPCODE_W-1:0] OP_BRANCH = OPCODE_W'(7'b1100011);
`ifdef MC_IMM_ALU_EN
   localparam logic [OPCODE_W-1:0] OP_IMM    = OPCODE_W'(7'b0010011);
`endif

   state_t state_reg;
   state_t state_next;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= FETCH;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      state         = 4'd0;
      retire        = 1'b0;
      illegal_op    = 1'b0;

      // Everything stays quiet while reset is asserted, so no memory strobe escapes.
      if (rst_n) begin
         state = state_reg;
         case (state_reg)
            FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = 2'b01;
               if (mem_ready) begin
                  ir_write   = 1'b1;
                  pc_write   = 1'b1;
                  state_next = DECODE;
               end
            end
            DECODE: begin
               alu_src_b = 2'b10;
               case (opcode)
                  OP_LOAD, OP_STORE: state_next = MEMADR;
                  OP_RTYPE:          state_next = EXEC_R;
                  OP_BRANCH:         state_next = BRANCH;
`ifdef MC_IMM_ALU_EN
                  OP_IMM:            state_next = EXEC_I;
`endif
                  default: begin
                     state_next = FETCH;
                     illegal_op = 1'b1;
                  end
               endcase
            end
            MEMADR: begin
               alu_src_a  = 1'b1;
               alu_src_b  = 2'b10;
               state_next = opcode[5] ? MEMWR : MEMRD;
            end
            MEMRD: begin
               mem_read = 1'b1;
               i_or_d   = 1'b1;
               if (mem_ready) state_next = MEMWB;
            end
            MEMWB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
               retire     = 1'b1;
               state_next = FETCH;
            end
            MEMWR: begin
               mem_write = 1'b1;
               i_or_d    = 1'b1;
               if (mem_ready) begin
                  retire     = 1'b1;
                  state_next = FETCH;
               end
            end
            EXEC_R: begin
               alu_src_a  = 1'b1;
               alu_op     = 2'b10;
               state_next = ALUWB;
            end
`ifdef MC_IMM_ALU_EN
            EXEC_I: begin
               alu_src_a  = 1'b1;
               alu_src_b  = 2'b10;
               alu_op     = 2'b10;
               state_next = ALUWB;
            end
`endif
            ALUWB: begin
               reg_write  = 1'b1;
               retire     = 1'b1;
               state_next = FETCH;
            end
            BRANCH: begin
               alu_src_a     = 1'b1;
               alu_op        = 2'b01;
               pc_write_cond = 1'b1;
               pc_source     = 1'b1;
               retire        = 1'b1;
               state_next    = FETCH;
            end
            default: begin
               // Unreachable encodings recover to FETCH with every strobe low.
               state      = 4'd0;
               state_next = FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: per-instruction expected state/strobe traces.
// Honours MC_IMM_ALU_EN the same way the design does.
module tb_multicycle_control;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BAD = 7'b1111111;

   localparam int C_LW = 0, C_SW = 1, C_R = 2, C_BEQ = 3, C_I = 4, C_ILL = 5;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       mem_ready = 1'b0;
   logic [6:0] opcode = 7'd0;
   logic       pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write;
   logic       ir_write, reg_write, mem_to_reg, alu_src_a, retire, illegal_op;
   logic [1:0] alu_src_b, alu_op;
   logic [3:0] state;

   int n_checks = 0;
   int n_fail = 0;

   multicycle_control #(.OPCODE_W(7)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
      .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
      .ir_write(ir_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .state(state), .retire(retire), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   wire [15:0] out_vec = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                          ir_write, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                          retire, illegal_op};

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int class_of(input logic [6:0] op);
      if (op == OP_LW) return C_LW;
      if (op == OP_SW) return C_SW;
      if (op == OP_R) return C_R;
      if (op == OP_BEQ) return C_BEQ;
`ifdef MC_IMM_ALU_EN
      if (op == OP_I) return C_I;
`endif
      return C_ILL;
   endfunction

   // Strobe table for one cycle spent in state st with the given mem_ready and opcode.
   function automatic logic [15:0] exp_vec(input int st, input bit rdy, input logic [6:0] op);
      logic pcw, pcc, pcs, iod, mr, mw, irw, rw, m2r, asa, ret, ill;
      logic [1:0] asb, aop;
      {pcw, pcc, pcs, iod, mr, mw, irw, rw, m2r, asa, ret, ill} = '0;
      asb = 2'b00;
      aop = 2'b00;
      case (st)
         0: begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
         1: begin asb = 2'b10; ill = (class_of(op) == C_ILL); end
         2: begin asa = 1; asb = 2'b10; end
         3: begin mr = 1; iod = 1; end
         4: begin rw = 1; m2r = 1; ret = 1; end
         5: begin mw = 1; iod = 1; ret = rdy; end
         6: begin asa = 1; aop = 2'b10; end
         7: begin rw = 1; ret = 1; end
         8: begin asa = 1; aop = 2'b01; pcc = 1; pcs = 1; ret = 1; end
         9: begin asa = 1; asb = 2'b10; aop = 2'b10; end
         default: ;
      endcase
      return {pcw, pcc, pcs, iod, mr, mw, irw, rw, m2r, asa, asb, aop, ret, ill};
   endfunction

   task automatic step(input bit rst_v, input bit rdy, input logic [6:0] op);
      @(posedge clk);
      #1;
      rst_n = rst_v;
      mem_ready = rdy;
      opcode = op;
      @(negedge clk);
   endtask

   // Runs one instruction from FETCH: fw stalled fetch cycles, mw stalled memory cycles.
   task automatic run_instr(input logic [6:0] op, input int fw, input int mw);
      int  sts[$];
      bit  rdys[$];
      int  cls;
      int  n_ret;
      int  n_ill;
      logic [6:0] drv;
      cls = class_of(op);
      for (int i = 0; i < fw; i++) begin sts.push_back(0); rdys.push_back(1'b0); end
      sts.push_back(0); rdys.push_back(1'b1);
      sts.push_back(1); rdys.push_back(1'($urandom));
      case (cls)
         C_LW: begin
            sts.push_back(2); rdys.push_back(1'($urandom));
            for (int i = 0; i < mw; i++) begin sts.push_back(3); rdys.push_back(1'b0); end
            sts.push_back(3); rdys.push_back(1'b1);
            sts.push_back(4); rdys.push_back(1'($urandom));
         end
         C_SW: begin
            sts.push_back(2); rdys.push_back(1'($urandom));
            for (int i = 0; i < mw; i++) begin sts.push_back(5); rdys.push_back(1'b0); end
            sts.push_back(5); rdys.push_back(1'b1);
         end
         C_R: begin
            sts.push_back(6); rdys.push_back(1'($urandom));
            sts.push_back(7); rdys.push_back(1'($urandom));
         end
         C_I: begin
            sts.push_back(9); rdys.push_back(1'($urandom));
            sts.push_back(7); rdys.push_back(1'($urandom));
         end
         C_BEQ: begin
            sts.push_back(8); rdys.push_back(1'($urandom));
         end
         default: ;
      endcase
      n_ret = 0;
      n_ill = 0;
      for (int i = 0; i < sts.size(); i++) begin
         // The opcode is irrelevant during FETCH, so it is scrambled there.
         drv = (sts[i] == 0) ? 7'($urandom) : op;
         step(1'b1, rdys[i], drv);
         check_val("cycle", {12'd0, state, out_vec}, {12'd0, 4'(sts[i]), exp_vec(sts[i], rdys[i], drv)});
         n_ret += int'(retire);
         n_ill += int'(illegal_op);
      end
      check_val("retire_count", n_ret, (cls == C_ILL) ? 0 : 1);
      check_val("illegal_count", n_ill, (cls == C_ILL) ? 1 : 0);
      $display("instr op=%b class=%0d fetch_wait=%0d mem_wait=%0d cycles=%0d retire=%0d illegal=%0d",
               op, cls, fw, mw, sts.size(), n_ret, n_ill);
   endtask

   logic [6:0] op_pool [6];

   initial begin
      op_pool[0] = OP_LW;  op_pool[1] = OP_SW;  op_pool[2] = OP_R;
      op_pool[3] = OP_BEQ; op_pool[4] = OP_I;   op_pool[5] = OP_BAD;

      // Reset held for three cycles with mem_ready high: everything must be zero.
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 7'($urandom));
         check_val("reset_outputs", {12'd0, state, out_vec}, 32'd0);
      end
      $display("reset held 3 cycles");

      // Directed sequences covering the main instruction shapes.
      run_instr(OP_LW, 0, 0);
      run_instr(OP_R, 2, 0);
      run_instr(OP_SW, 0, 1);
      run_instr(OP_BEQ, 0, 0);
      run_instr(OP_I, 0, 0);
      run_instr(OP_BAD, 0, 0);

      // Reset during MEMRD: instruction abandoned, back in FETCH, no write-back.
      step(1'b1, 1'b1, OP_LW);
      check_val("mr_fetch", {12'd0, state, out_vec}, {12'd0, 4'd0, exp_vec(0, 1'b1, OP_LW)});
      step(1'b1, 1'b0, OP_LW);
      check_val("mr_decode", state, 4'd1);
      step(1'b1, 1'b0, OP_LW);
      check_val("mr_memadr", state, 4'd2);
      step(1'b1, 1'b0, OP_LW);
      check_val("mr_memrd", {12'd0, state, out_vec}, {12'd0, 4'd3, exp_vec(3, 1'b0, OP_LW)});
      step(1'b0, 1'b1, OP_LW);
      check_val("mr_in_reset", {12'd0, state, out_vec}, 32'd0);
      step(1'b1, 1'b0, OP_LW);
      check_val("mr_after_reset", {12'd0, state, out_vec}, {12'd0, 4'd0, exp_vec(0, 1'b0, OP_LW)});
      $display("reset during MEMRD recovered to FETCH");

      // Randomized instruction stream, including arbitrary opcodes.
      for (int n = 0; n < 150; n++) begin
         logic [6:0] op;
         if ($urandom_range(0, 7) == 0) op = 7'($urandom);
         else op = op_pool[$urandom_range(0, 5)];
         run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
